// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: streams a captured word MSB-first into a serial sequence
// detector, one bit strobe every GAP+1 cycles, and collects the detector's
// Z output per bit into a result mask plus a population count.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | in_ready=1, waiting for a word
// CLEAR  | one-cycle det_clr pulse before the word (CLR_ON_WORD=1 only)
// SHIFT  | det_en strobe, det_x = current MSB, det_z captured at the edge
// GAP    | GAP idle cycles between strobes, det_en=0, det_x=0
// DONE   | out_valid=1, result held until out_ready
module seq_det_ctrl #(
  parameter int WIDTH       = 8,
  parameter int GAP         = 0,
  parameter bit CLR_ON_WORD = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         abort,
  output logic                         det_x,
  output logic                         det_en,
  output logic                         det_clr,
  input  logic                         det_z,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_mask,
  output logic [$clog2(WIDTH+1)-1:0]   out_count
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam bit            HAS_GAP  = (GAP > 0);
  // GAP state is a down-counter loaded with GAP-1 and left at terminal count 0
  localparam logic [3:0]    GAP_LOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;
  localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);

  logic [2:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [IW-1:0]    idx;
  logic [3:0]       gap_cnt;

  // Moore outputs decoded from state; det_x is gated so it is 0 off-strobe
  assign in_ready  = (state == S_IDLE);
  assign det_clr   = (state == S_CLEAR);
  assign det_en    = (state == S_SHIFT);
  assign det_x     = (state == S_SHIFT) & sreg[WIDTH-1];
  assign out_valid = (state == S_DONE);

  // Sequencing FSM with shift register, bit index and result accumulation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      sreg      <= '0;
      idx       <= '0;
      gap_cnt   <= '0;
      out_mask  <= '0;
      out_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sreg      <= in_data;
            out_mask  <= '0;
            out_count <= '0;
            idx       <= IDX_TOP;
            state     <= CLR_ON_WORD ? S_CLEAR : S_SHIFT;
          end
        end
        S_CLEAR: begin
          state <= abort ? S_IDLE : S_SHIFT;
        end
        S_SHIFT: begin
          // abort wins over the strobe, including the final one
          if (abort) begin
            state <= S_IDLE;
          end else begin
            out_mask[idx] <= det_z;
            if (det_z) out_count <= out_count + CW'(1);
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            if (idx == '0) begin
              state <= S_DONE;
            end else begin
              idx <= idx - IW'(1);
              if (HAS_GAP) begin
                gap_cnt <= GAP_LOAD;
                state   <= S_GAP;
              end else begin
                state <= S_SHIFT;
              end
            end
          end
        end
        S_GAP: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (gap_cnt == 4'd0) begin
            state <= S_SHIFT;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bits per word, range 2..32.
REQ-002 Parameter GAP, default 0: idle cycles between successive bit strobes, range 0..15.
REQ-003 Parameter CLR_ON_WORD, default 1: when 1, the detector is cleared before each word.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  a word is offered on in_data.
REQ-007 in_ready  output  1  the controller accepts a word this cycle.
REQ-008 in_data  input  WIDTH  word to stream; MSB is sent first.
REQ-009 abort  input  1  synchronous cancel of the word in progress.
REQ-010 det_x  output  1  serial bit to the detector's X input.
REQ-011 det_en  output  1  one-cycle bit strobe to the detector's en input.
REQ-012 det_clr  output  1  one-cycle clear pulse to the detector's reset input, active-high.
REQ-013 det_z  input  1  detector Z output (Mealy), sampled in det_en cycles only.
REQ-014 out_valid  output  1  result is available.
REQ-015 out_ready  input  1  the consumer accepts the result.
REQ-016 out_mask  output  WIDTH  bit i is set if det_z=1 in the strobe cycle of in_data[i].
REQ-017 out_count  output  clog2(WIDTH+1)  number of set bits in out_mask.

Function
REQ-018 The controller SHALL be a Moore FSM with states IDLE, CLEAR, SHIFT, GAP and DONE; no other outputs are combinational from inputs.
REQ-019 in_ready SHALL be 1 only in IDLE; a word is accepted when in_valid and in_ready are both 1, and in_data is captured into the shift register.
REQ-020 Accept SHALL go to CLEAR if CLR_ON_WORD=1, otherwise to SHIFT; CLEAR lasts 1 cycle with det_clr=1 and then goes to SHIFT.
REQ-021 SHIFT cycle: det_en=1 and det_x=current MSB of the shift register; at the clock edge, det_z is written into out_mask[bit index], out_count is incremented if det_z=1, and the register shifts left by one.
REQ-022 After a non-final bit, the FSM SHALL go to GAP for exactly GAP cycles (det_en=0) if GAP>0, otherwise directly to SHIFT; after the final bit (index 0) it SHALL go to DONE.
REQ-023 Bit strobes SHALL be spaced GAP+1 cycles apart; a word takes WIDTH strobes, and out_valid SHALL rise on the cycle after the last strobe.
REQ-024 Latency from accept to out_valid SHALL be CLR_ON_WORD + WIDTH + (WIDTH-1)*GAP + 1 cycles.
REQ-025 DONE SHALL hold out_valid=1 with stable out_mask and out_count until out_ready=1, then go to IDLE; no new word is accepted in that same cycle.
REQ-026 out_mask and out_count SHALL be zeroed on accept and remain unchanged in IDLE.
REQ-027 det_x SHALL be 0 whenever det_en=0.
REQ-028 abort=1 in CLEAR, SHIFT or GAP SHALL force IDLE at the next edge with no out_valid pulse; abort is ignored in IDLE and DONE.
REQ-029 abort and the final strobe in the same cycle SHALL resolve as abort.
REQ-030 out_count SHALL never exceed WIDTH and SHALL not wrap.

Reset
REQ-031 When rst=0 the FSM SHALL immediately enter IDLE, with det_en=0, det_x=0, det_clr=0, out_valid=0, out_mask=0, out_count=0, the shift register cleared and in_ready=1.
REQ-032 Reset asserted mid-word SHALL discard the word, and no result is produced after release.
REQ-033 Release of rst SHALL be followed by normal operation on the first rising edge after release.

Verification
REQ-034 WIDTH=8, GAP=0, CLR=1, word 8'hA5, det_z tied 0: det_clr for 1 cycle, then 8 consecutive strobes with det_x=1,0,1,0,0,1,0,1; out_valid 10 cycles after accept; out_mask=0, out_count=0.
REQ-035 Same setup with det_z=1 in the 2nd and 7th strobe cycles: out_mask=8'h42, out_count=2.
REQ-036 GAP=3, CLR=0: strobes exactly 4 cycles apart; out_valid 1+8+21=30 cycles after accept; det_x=0 in all GAP cycles.
REQ-037 abort asserted in the 4th strobe cycle: IDLE next cycle, no out_valid, in_ready=1; a following word then completes normally.
REQ-038 out_ready held 0 for 5 cycles in DONE: outputs stable and in_ready=0 throughout; rst pulsed low mid-SHIFT: all outputs return to the REQ-031 values asynchronously.
